flick_conditioner: RTL and testbench
====================================

// Module: flick_conditioner
// PURPOSE
//  Input-conditioning stage directly upstream of bound_flasher: takes the raw,
//  asynchronous flick push-button level and delivers a synchronized, debounced
//  flick level (drives bound_flasher.flick) plus one-cycle rise/fall strobes.
//  Rejects pulses shorter than the debounce window; output is glitch-free and registered.
// PARAMETERS
//  SYNC_STAGES      2   synchronizer flop count (legal: >= 2)
//  DEBOUNCE_CYCLES  4   consecutive stable synced samples required beyond the first (legal: >= 1)
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  derived localparam, debounce counter width
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst_n       in   1  asynchronous active-low reset
//  flick_raw   in   1  raw button level, asynchronous to clk
//  flick       out  1  debounced level; connect to bound_flasher.flick
//  flick_rise  out  1  one-cycle strobe, same edge flick goes 0->1
//  flick_fall  out  1  one-cycle strobe, same edge flick goes 1->0
//  busy        out  1  high while FSM is in ARM_HIGH or ARM_LOW
// BEHAVIOUR
//  - Reset (async assert, sync release via normal clocking): sync chain=0, cnt=0,
//    state=IDLE, flick=0, flick_rise=0, flick_fall=0, busy=0. Sync chain held at 0
//    masks X on flick_raw during reset.
//  - Sync: SYNC_STAGES-flop shift chain; FSM consumes only last stage (s_q).
//  - FSM states: IDLE (flick=0), ARM_HIGH, HIGH (flick=1), ARM_LOW.
//    IDLE:     s_q=1 -> ARM_HIGH, cnt<=0; else stay.
//    ARM_HIGH: s_q=0 -> IDLE (glitch rejected, no strobe);
//              s_q=1 & cnt==DEBOUNCE_CYCLES-1 -> HIGH, flick<=1, flick_rise<=1;
//              else cnt<=cnt+1.
//    HIGH:     s_q=0 -> ARM_LOW, cnt<=0; else stay.
//    ARM_LOW:  s_q=1 -> HIGH (no strobe); s_q=0 & cnt==DEBOUNCE_CYCLES-1 -> IDLE,
//              flick<=0, flick_fall<=1; else cnt<=cnt+1.
//  - Latency: flick_raw rising and held -> flick=1 at rising edge number
//    SYNC_STAGES+DEBOUNCE_CYCLES+1 after first sampling edge (7 with defaults).
//    Falling symmetric. Minimum accepted pulse = DEBOUNCE_CYCLES+1 clk cycles
//    at the synchronizer output.
//  - Strobes are registered, exactly one cycle wide, never both high together;
//    flick_rise/fall coincide with the flick edge (same clock edge).
//  - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap. cnt only meaningful in ARM_*.
//  - Unreachable state encodings -> IDLE, flick=0.
//  - Reset mid-debounce or while HIGH: outputs drop to 0 immediately (async);
//    no fall strobe issued. If flick_raw is still high after release, a fresh
//    full debounce runs and flick_rise fires at edge S+D+1 after release.
//  - busy is a combinational decode of state registers (no raw-input path).
// STRUCTURE
//  - Shared header bound_flasher_defs.vh: FSM state encodings (2-bit IDLE=0,
//    ARM_HIGH=1, HIGH=2, ARM_LOW=3) and default DEBOUNCE_CYCLES, so the bench
//    and bound_flasher top level use the same values.
//  - One sub-module: sync_ff (parameterized N-stage reset-to-0 synchronizer),
//    reusable for rst_n release synchronization elsewhere in the design.
//  - FSM + counter + strobe registers live in flick_conditioner itself.
// TESTING (CYCLE=2, defaults S=2, D=4)
//  1. Hold flick_raw=1 from reset release -> flick=1 and flick_rise=1 exactly at
//     edge 7, flick_rise=0 at edge 8, busy high on edges 3..6.
//  2. flick_raw=1 for 3 cycles then 0 -> flick stays 0, no strobes, FSM back to IDLE.
//  3. Stable high, then raw low for 2 cycles and high again -> flick stays 1,
//     no flick_fall; then low for 10 cycles -> flick_fall 1 cycle, flick=0 at edge 7.
//  4. Bounce train 1,0,1,0,1 (1 cycle each) then steady 1 -> single flick_rise,
//     timed from last 0->1 transition (+7 edges).
//  5. Assert rst_n=0 while in ARM_HIGH and while in HIGH -> flick/strobes/busy 0
//     within the same cycle; release with raw=1 -> flick_rise 7 edges later.
//  6. Integrated with bound_flasher, flick_raw driven X until time 60, then 1:
//     flick never X after reset; led_state sequence matches direct-drive run delayed 7 cycles.

Source files
------------

// File: rtl/flick_conditioner_pkg.sv
// Shared definitions for the flick input-conditioning stage.
package flick_conditioner_pkg;

   localparam int unsigned SYNC_STAGES_DEF     = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

   // Debounce FSM encodings, shared with the downstream bound_flasher.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARM_HIGH = 2'd1,
      ST_HIGH     = 2'd2,
      ST_ARM_LOW  = 2'd3
   } flick_state_e;

   // True while a level change is being qualified.
   function automatic logic is_arming(input flick_state_e s);
      return (s == ST_ARM_HIGH) || (s == ST_ARM_LOW);
   endfunction

endpackage

// File: rtl/flick_conditioner_sync_ff.sv
// N-stage reset-to-0 synchronizer; reusable for reset-release synchronization.
module sync_ff #(
   parameter int unsigned N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [N-1:0] chain;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[N-2:0], d};
      end
   end

   assign q = chain[N-1];

endmodule

// File: rtl/flick_conditioner.sv
// Synchronizes and debounces the raw flick button; emits level plus edge strobes.
module flick_conditioner
   import flick_conditioner_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flick_raw,
   output logic flick,
   output logic flick_rise,
   output logic flick_fall,
   output logic busy
);

   localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s_q;
   flick_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flick_d, rise_d, fall_d;

   sync_ff #(.N(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (flick_raw),
      .q     (s_q)
   );

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         flick      <= 1'b0;
         flick_rise <= 1'b0;
         flick_fall <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         flick      <= flick_d;
         flick_rise <= rise_d;
         flick_fall <= fall_d;
      end
   end

   // Next-state: a level is accepted only after DEBOUNCE_CYCLES further matching samples.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flick_d = flick;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            flick_d = 1'b0;
            if (s_q) begin
               state_d = ST_ARM_HIGH;
               cnt_d   = '0;
            end
         end
         ST_ARM_HIGH: begin
            if (!s_q) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               flick_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            flick_d = 1'b1;
            if (!s_q) begin
               state_d = ST_ARM_LOW;
               cnt_d   = '0;
            end
         end
         ST_ARM_LOW: begin
            if (s_q) begin
               state_d = ST_HIGH;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               flick_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            flick_d = 1'b0;
         end
      endcase
   end

   assign busy = is_arming(state_q);

endmodule

// File: tb/tb_flick_conditioner.sv
// Bench for flick_conditioner: directed timing pins plus randomized run vs a run-length model.
module tb_flick_conditioner;

   localparam int unsigned S   = 2;
   localparam int unsigned D   = 4;
   localparam int unsigned LAT = S + D + 1;

   logic clk       = 1'b0;
   logic rst_n     = 1'b0;
   logic flick_raw = 1'b0;
   logic flick, flick_rise, flick_fall, busy;

   int n_cmp = 0;
   int n_bad = 0;

   flick_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flick_raw  (flick_raw),
      .flick      (flick),
      .flick_rise (flick_rise),
      .flick_fall (flick_fall),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: synced stream is the raw input delayed S edges; the output level
   // follows the synced value once a run of it reaches D+1 samples.
   bit syncq[$];
   bit run_val;
   int run_len;
   bit m_flick, m_rise, m_fall, m_last;

   always @(posedge clk or negedge rst_n) begin
      bit s;
      if (!rst_n) begin
         syncq = {};
         for (int i = 0; i < S; i++) syncq.push_back(1'b0);
         run_val = 1'b0;
         run_len = 0;
         m_flick = 1'b0;
         m_rise  = 1'b0;
         m_fall  = 1'b0;
         m_last  = 1'b0;
      end else begin
         s = syncq[S-1];
         void'(syncq.pop_back());
         syncq.push_front(flick_raw);
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (s == run_val) begin
            if (run_len < D + 2) run_len++;
         end else begin
            run_val = s;
            run_len = 1;
         end
         if (s != m_flick && run_len == D + 1) begin
            m_flick = s;
            m_rise  = s;
            m_fall  = !s;
         end
         m_last = s;
      end
   end

   // Every-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      chk("cmp_flick", flick, m_flick);
      chk("cmp_rise",  flick_rise, m_rise);
      chk("cmp_fall",  flick_fall, m_fall);
      chk("cmp_busy",  busy, m_last != m_flick);
   end

   task automatic hold(input bit v, input int n);
      @(negedge clk);
      flick_raw = v;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      flick_raw = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Release reset with raw held high; rise must land exactly LAT edges later.
   task automatic release_and_check_rise(input string tag);
      @(negedge clk);
      rst_n     = 1'b1;
      flick_raw = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         @(posedge clk);
         #1;
         chk({tag, "_flick"}, flick, e >= LAT);
         chk({tag, "_rise"},  flick_rise, e == LAT);
         chk({tag, "_busy"},  busy, (e >= S + 1) && (e < LAT));
      end
   endtask

   task automatic assert_reset_midcycle(input string tag);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, "_flick"}, flick, 1'b0);
      chk({tag, "_rise"},  flick_rise, 1'b0);
      chk({tag, "_fall"},  flick_fall, 1'b0);
      chk({tag, "_busy"},  busy, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_flick", flick, 1'b0);
      chk("rst_rise",  flick_rise, 1'b0);
      chk("rst_fall",  flick_fall, 1'b0);
      chk("rst_busy",  busy, 1'b0);

      // Held high from release
      release_and_check_rise("t1");

      // Short low blip while high is absorbed; then a real fall
      for (int e = 1; e <= 14; e++) begin
         @(negedge clk);
         flick_raw = !(e == 1 || e == 2);
         @(posedge clk);
         #1;
         chk("t3_hold_flick", flick, 1'b1);
         chk("t3_hold_fall",  flick_fall, 1'b0);
      end
      for (int e = 1; e <= 9; e++) begin
         @(negedge clk);
         flick_raw = 1'b0;
         @(posedge clk);
         #1;
         chk("t3_fall_flick", flick, e < LAT);
         chk("t3_fall_fall",  flick_fall, e == LAT);
      end

      // Three-cycle pulse is rejected
      do_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         @(negedge clk);
         flick_raw = (e <= 3);
         @(posedge clk);
         #1;
         chk("t2_flick", flick, 1'b0);
         chk("t2_rise",  flick_rise, 1'b0);
      end
      chk("t2_idle_busy", busy, 1'b0);

      // Bounce train then steady high: single rise timed from last 0->1
      for (int e = 1; e <= 14; e++) begin
         @(negedge clk);
         flick_raw = (e >= 5) ? 1'b1 : ((e % 2) == 1);
         @(posedge clk);
         #1;
         chk("t4_flick", flick, e >= 5 + LAT - 1);
         chk("t4_rise",  flick_rise, e == 5 + LAT - 1);
      end

      // Reset while arming high
      hold(1'b0, 12);
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         flick_raw = 1'b1;
         @(posedge clk);
      end
      #1;
      chk("t5_armed_busy", busy, 1'b1);
      assert_reset_midcycle("t5a");
      release_and_check_rise("t5a_rel");

      // Reset while high: no fall strobe, fresh debounce after release
      hold(1'b1, 3);
      #6;
      chk("t5_high_flick", flick, 1'b1);
      assert_reset_midcycle("t5b");
      release_and_check_rise("t5b_rel");

      // Randomized segments with occasional mid-cycle resets
      for (int k = 0; k < 300; k++) begin
         hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
         if ($urandom_range(0, 39) == 0) begin
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      hold(1'b0, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
